// File: rtl/store_align_buffer.sv
// Store alignment buffer: decodes CPU stores into byte enables and lane-replicated data,
// queues them in an in-order FIFO, drains to data memory and flags loads hitting pending stores.
module store_align_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [1:0]                 st_type,
    output logic                       align_err,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic [31:0]                ld_addr,
    output logic                       ld_hit,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [29:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];

    logic          legal;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic          accept, push, pop;
    logic [AW-1:0] idx;

    always_comb begin
        legal     = 1'b0;
        be_new    = '0;
        wdata_new = st_data;
        case (st_type)
            2'b01: begin
                legal     = 1'b1;
                be_new    = 4'b0001 << st_addr[1:0];
                wdata_new = {4{st_data[7:0]}};
            end
            2'b10: begin
                legal     = ~st_addr[0];
                be_new    = st_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{st_data[15:0]}};
            end
            2'b11: begin
                legal     = (st_addr[1:0] == 2'b00);
                be_new    = '1;
                wdata_new = st_data;
            end
            default: ;
        endcase
    end

    // Readiness depends only on the registered count, so a same-cycle pop never frees a slot.
    assign st_ready  = (count != FULL_CNT);
    assign mem_valid = (count != '0);
    assign accept    = st_valid & st_ready;
    assign push      = accept & legal;
    assign pop       = mem_valid & mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            align_err <= 1'b0;
        end else begin
            align_err <= accept & ~legal;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= st_addr[31:2];
            data_mem[wr_ptr] <= wdata_new;
            be_mem[wr_ptr]   <= be_new;
        end
    end

    assign mem_addr  = {addr_mem[rd_ptr], 2'b00};
    assign mem_wdata = data_mem[rd_ptr];
    assign mem_be    = be_mem[rd_ptr];

    // Walk slots relative to the head so only occupied entries can hit.
    always_comb begin
        ld_hit = 1'b0;
        idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if ((CW'(i) < count) && (addr_mem[idx] == ld_addr[31:2])) ld_hit = 1'b1;
        end
    end

endmodule

// File: tb/tb_store_align_buffer.sv
// Scoreboard bench for store_align_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based model of pending stores.
module tb_store_align_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_type;
    logic        align_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    store_align_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_type   (st_type),
        .align_err (align_err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .count     (count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ent_t;

    ent_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   err_exp    = 1'b0;
    bit   full_pre   = 1'b0;
    bit   last_acc   = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: store semantics expressed with plain arithmetic.
    function automatic bit lane_model(input logic [31:0] a, input logic [31:0] d,
                                      input logic [1:0] t, output ent_t e);
        int unsigned off;
        off     = a % 4;
        e.addr  = a - off;
        e.wdata = d;
        e.be    = 4'b0000;
        case (t)
            2'd1: begin
                e.be    = 4'(1 << off);
                e.wdata = (d % 256) * 32'h0101_0101;
                return 1'b1;
            end
            2'd2: begin
                e.be    = (off >= 2) ? 4'b1100 : 4'b0011;
                e.wdata = (d % 65536) * 32'h0001_0001;
                return (off % 2) == 0;
            end
            2'd3: begin
                e.be = 4'b1111;
                return off == 0;
            end
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: compares the DUT against the pending-store model mid-cycle, then retires the head.
    always @(negedge clk) begin
        if (reset_n) begin
            int  n;
            bit  hit;
            n = exp_q.size();
            chk("count", 32'(count), 32'(n));
            chk("st_ready", 32'(st_ready), 32'(n < DEPTH));
            chk("mem_valid", 32'(mem_valid), 32'(n != 0));
            chk("align_err", 32'(align_err), 32'(err_exp));
            hit = 1'b0;
            foreach (exp_q[i]) if ((exp_q[i].addr / 4) == (ld_addr / 4)) hit = 1'b1;
            chk("ld_hit", 32'(ld_hit), 32'(hit));
            if (n != 0) begin
                chk("mem_addr", mem_addr, exp_q[0].addr);
                chk("mem_wdata", mem_wdata, exp_q[0].wdata);
                chk("mem_be", 32'(mem_be), 32'(exp_q[0].be));
            end
            full_pre = (n >= DEPTH);
            if (n != 0 && mem_ready) void'(exp_q.pop_front());
        end
    end

    // One clock: account for what the model says happens at this edge, then allow new stimulus.
    task automatic step();
        ent_t e;
        bit   legal;
        @(posedge clk);
        legal    = lane_model(st_addr, st_data, st_type, e);
        last_acc = reset_n && st_valid && !full_pre;
        if (last_acc && legal) exp_q.push_back(e);
        err_exp = last_acc && !legal;
        #1;
        if (rand_ready) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            ld_addr   = 32'h4000 + $urandom_range(0, 31);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        int tries;
        st_addr  = a;
        st_data  = d;
        st_type  = t;
        st_valid = 1'b1;
        tries    = 0;
        do begin
            step();
            tries++;
        end while (!last_acc && tries < 200);
        if (!last_acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: store 0x%08h not accepted after %0d cycles", a, tries);
        end
        st_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_type   = '0;
        mem_ready = 1'b0;
        ld_addr   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_align_err", 32'(align_err), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Byte store into lane 3, drained immediately
        mem_ready = 1'b1;
        send(32'h0000_1003, 32'h0000_00A5, 2'b01);
        chk("t1_mem_valid", 32'(mem_valid), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h0000_1000);
        chk("t1_mem_be", 32'(mem_be), 32'b1000);
        chk("t1_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        step();
        chk("t1_count", 32'(count), 32'd0);

        // Half stores and alignment errors
        send(32'h0000_2002, 32'h1234_BEEF, 2'b10);
        chk("t2_mem_be", 32'(mem_be), 32'b1100);
        chk("t2_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
        send(32'h0000_2001, 32'h1234_BEEF, 2'b10);
        chk("t2_err_half", 32'(align_err), 32'd1);
        step();
        chk("t2_err_clear", 32'(align_err), 32'd0);
        send(32'h0000_2002, 32'h1234_5678, 2'b11);
        chk("t2_err_word", 32'(align_err), 32'd1);
        send(32'h0000_2000, 32'h1234_5678, 2'b00);
        chk("t2_err_type0", 32'(align_err), 32'd1);
        idle(3);

        // Fill to full, hold a fifth store, then drain in order
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(32'h10 + 32'(4 * k), $urandom, 2'b11);
        chk("t3_count_full", 32'(count), 32'd4);
        chk("t3_st_ready_full", 32'(st_ready), 32'd0);
        st_addr  = 32'h20;
        st_data  = 32'hCAFE_F00D;
        st_type  = 2'b11;
        st_valid = 1'b1;
        idle(2);
        mem_ready = 1'b1;
        step();
        chk("t3_count_after_pop", 32'(count), 32'd3);
        chk("t3_st_ready_after_pop", 32'(st_ready), 32'd1);
        step();
        st_valid = 1'b0;
        idle(6);

        // Steady push+pop at count 2 across pointer wrap
        mem_ready = 1'b0;
        send(32'h100, $urandom, 2'b11);
        send(32'h104, $urandom, 2'b11);
        mem_ready = 1'b1;
        for (int k = 0; k < 10; k++) send(32'h200 + 32'(4 * k), $urandom, 2'(1 + k % 3));
        chk("t4_count", 32'(count), 32'd2);
        idle(4);

        // Load hit against a pending store
        mem_ready = 1'b0;
        send(32'h3004, 32'h77, 2'b01);
        ld_addr = 32'h3006;
        #1;
        chk("t5_hit", 32'(ld_hit), 32'd1);
        ld_addr = 32'h3008;
        #1;
        chk("t5_miss", 32'(ld_hit), 32'd0);
        mem_ready = 1'b1;
        idle(2);
        ld_addr = 32'h3006;
        #1;
        chk("t5_stale", 32'(ld_hit), 32'd0);

        // Randomized traffic
        rand_ready = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 4) < 3)
                send(32'h4000 + $urandom_range(0, 31), $urandom, 2'($urandom_range(0, 3)));
            else
                idle(1);
        end
        rand_ready = 1'b0;
        mem_ready  = 1'b1;
        idle(8);

        // Asynchronous reset with stores pending
        mem_ready = 1'b0;
        send(32'h5000, $urandom, 2'b11);
        send(32'h5004, $urandom, 2'b11);
        send(32'h5008, $urandom, 2'b11);
        ld_addr = 32'h5004;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_mem_valid", 32'(mem_valid), 32'd0);
        chk("t6_st_ready", 32'(st_ready), 32'd1);
        chk("t6_ld_hit", 32'(ld_hit), 32'd0);
        exp_q.delete();
        err_exp   = 1'b0;
        full_pre  = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
